// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises, edge/level-detects, latches and masks
// up to eight sources and drives CP0 HWInt plus a summary irq line.
module irq_ctrl #(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [N_SRC-1:0] src,
  output logic [N_SRC-1:0] hwint,
  output logic             irq
);

  localparam logic [1:0] A_MASK = 2'd0;
  localparam logic [1:0] A_PEND = 2'd1;
  localparam logic [1:0] A_MODE = 2'd2;

  logic [N_SRC-1:0] s1_r, s2_r, s3_r;
  logic [N_SRC-1:0] mask_r, pend_r, mode_r;
  logic [N_SRC-1:0] mask_next_s, pend_next_s, mode_next_s;
  logic [N_SRC-1:0] edge_s, clr_s, act_s;
  logic [2:0]       cur_idx_s;
  logic             wr_s;
  logic             unused_s;

  assign unused_s = ^wdata[31:N_SRC];
  assign edge_s   = s2_r & ~s3_r;
  assign act_s    = pend_r & mask_r;
  assign wr_s     = sel & we;

  // Next-state for mask, mode and pending; mode changes apply from the next cycle.
  always_comb begin
    mask_next_s = mask_r;
    mode_next_s = mode_r;
    clr_s       = {N_SRC{1'b0}};
    pend_next_s = pend_r;
    if (wr_s && (addr == A_MASK)) begin
      mask_next_s = wdata[N_SRC-1:0];
    end else begin
      mask_next_s = mask_r;
    end
    if (wr_s && (addr == A_MODE)) begin
      mode_next_s = wdata[N_SRC-1:0];
    end else begin
      mode_next_s = mode_r;
    end
    if (wr_s && (addr == A_PEND)) begin
      clr_s = wdata[N_SRC-1:0];
    end else begin
      clr_s = {N_SRC{1'b0}};
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (mode_r[i]) begin
        pend_next_s[i] = s2_r[i];
      end else if (edge_s[i]) begin
        pend_next_s[i] = 1'b1;
      end else if (clr_s[i]) begin
        pend_next_s[i] = 1'b0;
      end else begin
        pend_next_s[i] = pend_r[i];
      end
    end
  end

  // Lowest-numbered active source wins the CUR index.
  always_comb begin
    cur_idx_s = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (act_s[i]) begin
        cur_idx_s = 3'(i);
      end else begin
        cur_idx_s = cur_idx_s;
      end
    end
  end

  // Register read mux; idle bus returns zero.
  always_comb begin
    rdata = 32'd0;
    if (sel && !we) begin
      case (addr)
        2'd0:    rdata = {{(32-N_SRC){1'b0}}, mask_r};
        2'd1:    rdata = {{(32-N_SRC){1'b0}}, pend_r};
        2'd2:    rdata = {{(32-N_SRC){1'b0}}, mode_r};
        default: rdata = {|act_s, 28'd0, cur_idx_s};
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

  // Synchroniser, control registers and outputs built from next-state values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_r   <= {N_SRC{1'b0}};
      s2_r   <= {N_SRC{1'b0}};
      s3_r   <= {N_SRC{1'b0}};
      mask_r <= {N_SRC{1'b0}};
      pend_r <= {N_SRC{1'b0}};
      mode_r <= {N_SRC{1'b0}};
      hwint  <= {N_SRC{1'b0}};
      irq    <= 1'b0;
    end else begin
      s1_r   <= src;
      s2_r   <= s1_r;
      s3_r   <= s2_r;
      mask_r <= mask_next_s;
      pend_r <= pend_next_s;
      mode_r <= mode_next_s;
      hwint  <= pend_next_s & mask_next_s;
      irq    <= |(pend_next_s & mask_next_s);
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios then random traffic against a
// sample-history reference model of the controller.
module tb_irq_ctrl;
  localparam int N = 6;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          sel   = 1'b0;
  logic          we    = 1'b0;
  logic [1:0]    addr  = 2'd0;
  logic [31:0]   wdata = 32'd0;
  logic [31:0]   rdata;
  logic [N-1:0]  src   = '0;
  logic [N-1:0]  hwint;
  logic          irq;

  int total  = 0;
  int passed = 0;

  logic [N-1:0] m_mask = '0;
  logic [N-1:0] m_mode = '0;
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_hw   = '0;
  logic         m_irq  = 1'b0;
  logic [N-1:0] hist[$];

  irq_ctrl #(.N_SRC(N)) dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .src(src), .hwint(hwint), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_read(logic [1:0] a);
    logic [N-1:0] act;
    logic [31:0]  v;
    act = m_pend & m_mask;
    v = 32'd0;
    case (a)
      2'd0: v = 32'(m_mask);
      2'd1: v = 32'(m_pend);
      2'd2: v = 32'(m_mode);
      default: begin
        for (int i = 0; i < N; i++) begin
          if (act[i] && !v[31]) begin
            v = 32'h8000_0000 + 32'(i);
          end
        end
      end
    endcase
    return v;
  endfunction

  task automatic m_clear();
    m_mask = '0; m_mode = '0; m_pend = '0; m_hw = '0; m_irq = 1'b0;
    hist.delete();
  endtask

  // One rising edge of the model: sample seen two edges ago is the synchronised level.
  task automatic m_step(bit wr, logic [1:0] a, logic [31:0] d, logic [N-1:0] smp);
    logic [N-1:0] s2, s3;
    int n;
    n  = hist.size();
    s2 = (n >= 2) ? hist[n-2] : '0;
    s3 = (n >= 3) ? hist[n-3] : '0;
    for (int i = 0; i < N; i++) begin
      if (m_mode[i])              m_pend[i] = s2[i];
      else if (s2[i] && !s3[i])   m_pend[i] = 1'b1;
      else if (wr && a == 2'd1 && d[i]) m_pend[i] = 1'b0;
    end
    if (wr && a == 2'd0) m_mask = d[N-1:0];
    if (wr && a == 2'd2) m_mode = d[N-1:0];
    m_hw  = m_pend & m_mask;
    m_irq = (m_hw != '0);
    hist.push_back(smp);
    if (hist.size() > 4) void'(hist.pop_front());
  endtask

  task automatic tick(bit s, bit w, logic [1:0] a, logic [31:0] d);
    sel = s; we = w; addr = a; wdata = d;
    #1;
    if (s && !w) chk($sformatf("read%0d", a), rdata, m_read(a));
    @(posedge clk);
    if (!reset) m_clear();
    else        m_step(s && w, a, d, src);
    #1;
    chk("hwint", 32'(hwint), 32'(m_hw));
    chk("irq", 32'(irq), 32'(m_irq));
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic rd_const(string tag, logic [1:0] a, logic [31:0] exp);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    chk(tag, rdata, exp);
    sel = 1'b0;
  endtask

  initial begin
    // Reset held: inputs toggle, everything stays zero.
    for (int k = 0; k < 4; k++) begin
      src = N'($urandom);
      tick(1'b1, 1'b0, 2'(k), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
    end
    src = '0;
    reset = 1'b1;
    idle(3);

    tick(1'b1, 1'b1, 2'd0, 32'h3F);
    rd_const("mask_rb", 2'd0, 32'h3F);
    tick(1'b1, 1'b1, 2'd0, 32'hFFFF_FFFF);
    rd_const("mask_wide", 2'd0, 32'h3F);

    // Edge latency and W1C on source 0.
    tick(1'b1, 1'b1, 2'd0, 32'h01);
    tick(1'b1, 1'b1, 2'd2, 32'h00);
    src = 6'h01; idle(1);
    chk("lat_e0", 32'(hwint), 32'h0);
    idle(1);
    chk("lat_e1", 32'(hwint), 32'h0);
    src = 6'h00; idle(1);
    chk("lat_e2", 32'(hwint), 32'h1);
    rd_const("cur_src0", 2'd3, 32'h8000_0000);
    tick(1'b1, 1'b1, 2'd1, 32'h01);
    chk("w1c_hw", 32'(hwint), 32'h0);
    rd_const("w1c_cur", 2'd3, 32'h0);

    // Masked latch, then unmask.
    tick(1'b1, 1'b1, 2'd0, 32'h00);
    src = 6'h04; idle(2);
    src = 6'h00; idle(2);
    rd_const("pend_masked", 2'd1, 32'h04);
    chk("hw_masked", 32'(hwint), 32'h0);
    tick(1'b1, 1'b1, 2'd0, 32'h04);
    chk("unmask_hw", 32'(hwint), 32'h04);
    chk("unmask_irq", 32'(irq), 32'h1);

    // Priority between sources 1 and 4.
    tick(1'b1, 1'b1, 2'd0, 32'h3F);
    tick(1'b1, 1'b1, 2'd1, 32'h04);
    src = 6'h12; idle(2);
    src = 6'h00; idle(2);
    rd_const("prio_1", 2'd3, 32'h8000_0001);
    tick(1'b1, 1'b1, 2'd1, 32'h02);
    rd_const("prio_4", 2'd3, 32'h8000_0004);
    tick(1'b1, 1'b1, 2'd1, 32'h10);
    rd_const("prio_none", 2'd3, 32'h0);

    // Level mode on source 3.
    tick(1'b1, 1'b1, 2'd2, 32'h08);
    src = 6'h08; idle(4);
    rd_const("lvl_pend", 2'd1, 32'h08);
    tick(1'b1, 1'b1, 2'd1, 32'h08);
    rd_const("lvl_w1c", 2'd1, 32'h08);
    src = 6'h00; idle(2);
    chk("lvl_fall2", 32'(hwint[3]), 32'h1);
    idle(1);
    chk("lvl_fall3", 32'(hwint[3]), 32'h0);

    // Set and clear on the same edge: set wins.
    tick(1'b1, 1'b1, 2'd2, 32'h00);
    src = 6'h20; idle(2);
    tick(1'b1, 1'b1, 2'd1, 32'h20);
    chk("set_wins", 32'(hwint), 32'h20);
    src = 6'h00;

    // Asynchronous reset between edges.
    #2;
    reset = 1'b0;
    #1;
    chk("async_hw", 32'(hwint), 32'h0);
    chk("async_irq", 32'(irq), 32'h0);
    m_clear();
    idle(1);
    reset = 1'b1;
    idle(2);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      int op;
      src = N'($urandom);
      op  = $urandom_range(0, 3);
      case (op)
        0:       idle(1);
        1:       tick(1'b1, 1'b0, 2'($urandom_range(0, 3)), 32'd0);
        default: tick(1'b1, 1'b1, 2'($urandom_range(0, 3)), $urandom);
      endcase
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
